// File: rtl/bcd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_scan_ctrl
//
// Front end for a four-digit seven-segment display. A 10-bit binary value is
// converted to four BCD digits by an iterative shift-add-3 (double-dabble)
// engine behind a load/busy/done handshake. The finished result is held in
// display registers. A free-running scanner then time-multiplexes those
// digits onto one shared BCD-to-seven-segment decoder.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit stays selected (>= 2)
//
// Ports
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   value_in     binary value to convert (0..1023), captured on accepted load
//   load         convert request, accepted only while busy = 0
//   blank_lz     1 = suppress leading zeros on the display
//   busy         conversion in progress (accept .. latch, 11 cycles)
//   done         one-cycle pulse when the display registers take a result
//   digit_bcd    BCD code of the selected digit, feeds the shared decoder
//   digit_sel    one-hot select: bit0 units .. bit3 thousands
//   digit_blank  1 = selected digit is a suppressed leading zero
// ---------------------------------------------------------------------------
module bcd_scan_ctrl #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] value_in,
    input  logic       load,
    input  logic       blank_lz,
    output logic       busy,
    output logic       done,
    output logic [3:0] digit_bcd,
    output logic [3:0] digit_sel,
    output logic       digit_blank
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]       LAST_ITER = 4'd9;   // ten shifts: 0..9

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    // -----------------------------------------------------------------------
    // Converter state
    // -----------------------------------------------------------------------
    logic [1:0]       state;
    logic [25:0]      shift_reg;    // [25:10] BCD nibbles, [9:0] binary
    logic [3:0]       iter_cnt;
    logic [3:0][3:0]  disp_digits;  // [0] units .. [3] thousands

    // -----------------------------------------------------------------------
    // Scanner state
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       scan_idx;
    logic             blank_q;      // registered blank_lz keeps outputs input-free
    logic [3:0]       upper_zero;   // digit i and all above it are zero

    // One double-dabble iteration: correct every BCD nibble >= 5 by +3 so the
    // following left shift carries into the next decade, then shift.
    function automatic logic [25:0] dabble_step(input logic [25:0] sr);
        logic [25:0] adj;
        adj = sr;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sr[10 + 4*i +: 4] >= 4'd5) begin
                adj[10 + 4*i +: 4] = sr[10 + 4*i +: 4] + 4'd3;
            end
        end
        return {adj[24:0], 1'b0};
    endfunction

    // -----------------------------------------------------------------------
    // Conversion FSM
    // busy is set on the accepting edge and cleared on the latching edge, so a
    // load arriving during CONV or LATCH is simply not looked at.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            iter_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            disp_digits <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shift_reg <= {16'b0, value_in};
                        iter_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    shift_reg <= dabble_step(shift_reg);
                    iter_cnt  <= iter_cnt + 4'd1;
                    if (iter_cnt == LAST_ITER) begin
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    disp_digits <= shift_reg[25:10];
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Refresh scanner: each digit held for REFRESH_DIV cycles, index advances
    // on the edge where the counter wraps.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            blank_q     <= 1'b0;
        end else begin
            blank_q <= blank_lz;
            if (refresh_cnt == CNT_LAST) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output decode, purely from registers
    // -----------------------------------------------------------------------
    always_comb begin
        upper_zero[3] = (disp_digits[3] == 4'd0);
        upper_zero[2] = upper_zero[3] && (disp_digits[2] == 4'd0);
        upper_zero[1] = upper_zero[2] && (disp_digits[1] == 4'd0);
        upper_zero[0] = upper_zero[1] && (disp_digits[0] == 4'd0);
    end

    always_comb begin
        digit_sel = 4'b0001 << scan_idx;
        digit_bcd = disp_digits[scan_idx];
        // Units is never dark so a zero value still shows a single "0".
        digit_blank = blank_q && (scan_idx != 2'd0) && upper_zero[scan_idx];
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_ctrl
//
// Self-checking bench for bcd_scan_ctrl with a short refresh period. A
// reference model (conversion timer plus decimal arithmetic on the loaded
// value, scan position from a cycle count) predicts every output each cycle;
// directed sections exercise the handshake, scan order, ignored loads and
// mid-conversion reset; a back-to-back sweep and a random section follow.
// ---------------------------------------------------------------------------
module tb_bcd_scan_ctrl;

    localparam int RDIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] value_in = '0;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] digit_bcd;
    logic [3:0] digit_sel;
    logic       digit_blank;

    always #5 clk = ~clk;

    bcd_scan_ctrl #(.REFRESH_DIV(RDIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .load        (load),
        .blank_lz    (blank_lz),
        .busy        (busy),
        .done        (done),
        .digit_bcd   (digit_bcd),
        .digit_sel   (digit_sel),
        .digit_blank (digit_blank)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    //   m_timer : cycles until the pending result is shown (0 = idle)
    //   m_shown : decimal value currently on the display
    //   m_scan  : cycles since reset modulo one full scan
    // -----------------------------------------------------------------------
    int m_timer = 0;
    int m_value = 0;
    int m_shown = 0;
    bit m_done  = 1'b0;
    bit m_blank = 1'b0;
    int m_scan  = 0;
    int pow10 [4] = '{1, 10, 100, 1000};

    task automatic compare_outputs();
        int idx;
        idx = m_scan / RDIV;
        check("busy", busy, m_timer != 0);
        check("done", done, m_done);
        check("digit_sel", digit_sel, 1 << idx);
        check("digit_bcd", digit_bcd, (m_shown / pow10[idx]) % 10);
        check("digit_blank", digit_blank, m_blank && idx > 0 && m_shown < pow10[idx]);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_timer = 0;
            m_shown = 0;
            m_done  = 1'b0;
            m_blank = 1'b0;
            m_scan  = 0;
        end else begin
            m_done  = 1'b0;
            m_blank = blank_lz;
            m_scan  = (m_scan + 1) % (4 * RDIV);
            if (m_timer == 0) begin
                if (load) begin
                    m_timer = 11;
                    m_value = int'(value_in);
                end
            end else begin
                m_timer--;
                if (m_timer == 0) begin
                    m_shown = m_value;
                    m_done  = 1'b1;
                end
            end
        end
        #1;
        compare_outputs();
    end

    // -----------------------------------------------------------------------
    // Directed helpers
    // -----------------------------------------------------------------------
    logic [3:0] cap_sel [4];
    logic [3:0] cap_bcd [4];
    logic       cap_blk [4];
    int         cap_len [4];

    // Load v from idle; report edges from accept to done and cycles busy.
    task automatic run_load(input logic [9:0] v, output int lat, output int busy_cyc);
        @(negedge clk);
        value_in = v;
        load     = 1'b1;
        @(posedge clk); #1;
        load     = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            value_in = 10'($urandom);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Align to the start of a units window, then record one full scan.
    task automatic capture_scan(input string tag);
        logic [3:0] prev;
        int guard;
        prev  = digit_sel;
        guard = 0;
        @(posedge clk); #1;
        while (!(prev == 4'b1000 && digit_sel == 4'b0001) && guard < 10 * RDIV) begin
            prev = digit_sel;
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_sync"}, guard < 10 * RDIV, 1);
        for (int p = 0; p < 4; p++) begin
            cap_sel[p] = digit_sel;
            cap_bcd[p] = digit_bcd;
            cap_blk[p] = digit_blank;
            cap_len[p] = 0;
            prev = digit_sel;
            while (digit_sel == prev && cap_len[p] < 10 * RDIV) begin
                cap_len[p]++;
                @(posedge clk); #1;
            end
        end
    endtask

    // exp_bcd packs thousands..units as hex nibbles; exp_blk bit p = digit p.
    task automatic check_scan(input string tag, input logic [15:0] exp_bcd, input logic [3:0] exp_blk);
        logic [15:0] eb;
        logic [3:0]  ek;
        eb = exp_bcd;
        ek = exp_blk;
        capture_scan(tag);
        for (int p = 0; p < 4; p++) begin
            check({tag, "_sel"},   cap_sel[p], 1 << p);
            check({tag, "_len"},   cap_len[p], RDIV);
            check({tag, "_bcd"},   cap_bcd[p], eb[4*p +: 4]);
            check({tag, "_blank"}, cap_blk[p], ek[p]);
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int lat;
        int bcyc;
        int ndone;
        int next;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sel", digit_sel, 4'b0001);
        check("rst_bcd", digit_bcd, 0);
        check("rst_blank", digit_blank, 0);
        rst_n = 1'b1;

        // Zero with leading-zero suppression: only units lit.
        blank_lz = 1'b1;
        run_load(10'd0, lat, bcyc);
        check("zero_latency", lat, 11);
        check_scan("zero", 16'h0000, 4'b1110);

        // Maximum value, then 999 after done.
        blank_lz = 1'b0;
        run_load(10'd1023, lat, bcyc);
        check("max_latency", lat, 11);
        check("max_busy_len", bcyc, 11);
        check_scan("max", 16'h1023, 4'b0000);
        blank_lz = 1'b1;
        run_load(10'd999, lat, bcyc);
        check("n999_latency", lat, 11);
        check("n999_busy_len", bcyc, 11);
        check_scan("n999", 16'h0999, 4'b1000);

        // Scan order with 512: units 2, tens 1, hundreds 5, thousands 0.
        blank_lz = 1'b0;
        run_load(10'd512, lat, bcyc);
        check_scan("n512", 16'h0512, 4'b0000);

        // Load pulse at k+5 must be ignored.
        @(negedge clk);
        value_in = 10'd512;
        load     = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        value_in = 10'd7;
        load     = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("ignored_done_count", ndone, 1);
        check_scan("ignored", 16'h0512, 4'b0000);

        // Reset in the middle of a conversion.
        blank_lz = 1'b1;
        @(negedge clk);
        value_in = 10'd300;
        load     = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sel", digit_sel, 4'b0001);
        check("midrst_bcd", digit_bcd, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check_scan("midrst", 16'h0000, 4'b1110);

        // Back-to-back sweep of every value with load held high.
        next  = 0;
        ndone = 0;
        while (next < 1024) begin
            @(negedge clk);
            if (done) ndone++;
            if (m_timer == 0) begin
                value_in = 10'(next);
                load     = 1'b1;
                next++;
            end else begin
                value_in = 10'($urandom);
            end
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
        end
        @(negedge clk);
        load = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("sweep_done_count", ndone, 1024);

        // Random loads, gaps, blanking changes and one asynchronous reset.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            load     = ($urandom_range(0, 5) == 0);
            value_in = 10'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            if (c == 2000) rst_n = 1'b0;
            if (c == 2003) rst_n = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: reached %0t, limit 1000000", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
